tx_msg_sequencer: RTL

Parametrised UART transmit sequencer and next-generation message driver. It reads a fixed-length message from an external synchronous ROM, feeds it byte by byte to the UART transmitter through the XMitGo/TxEmpty handshake, then waits a programmable inter-message gap. It runs one-shot (on Start) or continuously, sits between the message ROM and the UART TX core, and reports progress through Busy/Done.

---
 rtl/tx_pkg.sv | 29 ++
 rtl/tx_msg_sequencer_if.sv | 36 +++
 rtl/tx_gap_timer.sv | 43 ++++
 rtl/tx_msg_sequencer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg: shared constants, FSM state encoding and width helper for the
// UART transmit message sequencer.
//   DATA_W, ADDR_W, MSG_LEN, MSG_BASE, GAP_CYCLES, CONTINUOUS: build defaults
//   tx_state_t / ST_*: sequencer state encoding
//   cnt_w(n): bits needed to hold 0..n without wrapping (at least 1)
package tx_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned MSG_LEN    = 16;
  localparam int unsigned MSG_BASE   = 0;
  localparam int unsigned GAP_CYCLES = 38_399;
  localparam bit          CONTINUOUS = 1'b1;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t ST_IDLE        = 3'd0;
  localparam tx_state_t ST_FETCH       = 3'd1;
  localparam tx_state_t ST_LOAD        = 3'd2;
  localparam tx_state_t ST_WAIT_READY  = 3'd3;
  localparam tx_state_t ST_GO          = 3'd4;
  localparam tx_state_t ST_WAIT_ACCEPT = 3'd5;
  localparam tx_state_t ST_GAP         = 3'd6;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tx_msg_sequencer_if.sv
// tx_msg_sequencer_if: handshake and bus signals between the message
// sequencer, the external synchronous ROM and the UART TX core.
//   Start   : begin one message (one-shot builds)
//   TxEmpty : UART transmitter ready/empty
//   RomData : ROM read data, valid one cycle after RomAddr
//   XMitGo  : one-cycle transmit strobe
//   TxData  : character presented to the UART
//   RomAddr : ROM read address
//   Busy    : sequencer outside IDLE
//   Done    : one-cycle pulse when a message completes
// master = sequencer side, slave = environment (ROM + UART) side.
interface tx_msg_sequencer_if #(
  parameter int unsigned DATA_W = tx_pkg::DATA_W,
  parameter int unsigned ADDR_W = tx_pkg::ADDR_W
);

  logic              Start;
  logic              TxEmpty;
  logic [DATA_W-1:0] RomData;
  logic              XMitGo;
  logic [DATA_W-1:0] TxData;
  logic [ADDR_W-1:0] RomAddr;
  logic              Busy;
  logic              Done;

  modport master (
    input  Start, TxEmpty, RomData,
    output XMitGo, TxData, RomAddr, Busy, Done
  );

  modport slave (
    output Start, TxEmpty, RomData,
    input  XMitGo, TxData, RomAddr, Busy, Done
  );

endinterface

// File: rtl/tx_gap_timer.sv
// tx_gap_timer: inter-message gap counter, counts 0..GAP_CYCLES.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : counts while high
//   clear_i    : forces the count back to zero (wins over start_i)
//   tc_c       : high for the single cycle the count sits at GAP_CYCLES
module tx_gap_timer #(
  parameter int unsigned GAP_CYCLES = tx_pkg::GAP_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clear_i,
  output logic tc_c
);
  import tx_pkg::*;

  localparam int unsigned     CNT_W = cnt_w(GAP_CYCLES);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(GAP_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count up while running; return to zero at terminal count so the gap
  // lasts exactly GAP_CYCLES+1 cycles and never wraps past TERM.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tc_c = start_i && (cnt_q == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_msg_sequencer.sv
// tx_msg_sequencer: reads a MSG_LEN-character message from an external
// synchronous ROM and hands it byte by byte to a UART TX core over the
// XMitGo/TxEmpty handshake, then waits GAP_CYCLES+1 cycles before the next
// message (CONTINUOUS=1) or returning to IDLE (CONTINUOUS=0).
//   Enable : clock, all logic on the rising edge
//   Reset  : asynchronous active-low reset
//   bus    : tx_msg_sequencer_if.master (Start, TxEmpty, RomData in;
//            XMitGo, TxData, RomAddr, Busy, Done out, all registered)
// Optional feature macro TX_CHECKSUM_EN: appends the XOR of all message
// characters as one extra character; Done then follows that character.
module tx_msg_sequencer #(
  parameter int unsigned DATA_W     = tx_pkg::DATA_W,
  parameter int unsigned ADDR_W     = tx_pkg::ADDR_W,
  parameter int unsigned MSG_LEN    = tx_pkg::MSG_LEN,
  parameter int unsigned MSG_BASE   = tx_pkg::MSG_BASE,
  parameter int unsigned GAP_CYCLES = tx_pkg::GAP_CYCLES,
  parameter bit          CONTINUOUS = tx_pkg::CONTINUOUS
) (
  input  logic                 Enable,
  input  logic                 Reset,
  tx_msg_sequencer_if.master   bus
);
  import tx_pkg::*;

  localparam int unsigned       IDX_W     = cnt_w(MSG_LEN);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(MSG_LEN);
  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(MSG_BASE);

  tx_state_t         state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  index_inc_c;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              xmit_go_q, xmit_go_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              gap_run_c, gap_clr_c, gap_tc_c;
`ifdef TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  assign gap_run_c = (state_q == ST_GAP);
  assign gap_clr_c = (state_q != ST_GAP);

  tx_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES)
  ) u_gap_timer (
    .clk     (Enable),
    .rst_n   (Reset),
    .start_i (gap_run_c),
    .clear_i (gap_clr_c),
    .tc_c    (gap_tc_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tx_data_d   = tx_data_q;
    rom_addr_d  = rom_addr_q;
    index_inc_c = index_q + IDX_W'(1);
`ifdef TX_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (CONTINUOUS || bus.Start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef TX_CHECKSUM_EN
        // Index at MSG_LEN marks the trailing checksum character.
        if (index_q == IDX_LAST) begin
          tx_data_d = csum_q;
        end else begin
          tx_data_d = bus.RomData;
          csum_d    = csum_q ^ bus.RomData;
        end
`else
        tx_data_d = bus.RomData;
`endif
        state_d = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (bus.TxEmpty) state_d = ST_GO;
      end
      ST_GO: begin
        state_d = ST_WAIT_ACCEPT;
      end
      ST_WAIT_ACCEPT: begin
        if (!bus.TxEmpty) begin
`ifdef TX_CHECKSUM_EN
          if (index_q == IDX_LAST) begin
            csum_d  = '0;
            state_d = ST_GAP;
          end else begin
            index_d = index_inc_c;
            // Checksum skips FETCH: nothing to read from the ROM.
            state_d = (index_inc_c == IDX_LAST) ? ST_LOAD : ST_FETCH;
          end
`else
          index_d = index_inc_c;
          state_d = (index_inc_c == IDX_LAST) ? ST_GAP : ST_FETCH;
`endif
        end
      end
      ST_GAP: begin
        if (gap_tc_c) begin
          index_d = '0;
          state_d = CONTINUOUS ? ST_FETCH : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Address is registered on FETCH entry so ROM data lands during LOAD.
    if (state_d == ST_FETCH) rom_addr_d = ADDR_BASE + ADDR_W'(index_d);

    xmit_go_d = (state_d == ST_GO);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_GAP) && (state_q != ST_GAP);
  end

  // State and output registers.
  always_ff @(posedge Enable or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      tx_data_q  <= '0;
      rom_addr_q <= ADDR_BASE;
      xmit_go_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      tx_data_q  <= tx_data_d;
      rom_addr_q <= rom_addr_d;
      xmit_go_q  <= xmit_go_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.XMitGo  = xmit_go_q;
  assign bus.TxData  = tx_data_q;
  assign bus.RomAddr = rom_addr_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;

endmodule
